// File: rtl/playbus_seq.sv
// PlayBus bus-cycle controller: sequences ROM/RAM/switch sources into
// RAM or LED sinks, with optional auto-incrementing block copy into RAM.
module playbus_seq #(
  parameter int AW          = 4,
  parameter int WR_CYCLES   = 1,
  parameter int HOLD_CYCLES = 1
) (
  input  logic          CK,
  input  logic          n_CLR,
  input  logic          GO,
  input  logic          BLOCK,
  input  logic [2:0]    FUNC,
  input  logic [AW-1:0] ADD_IN,
  output logic [AW-1:0] ADD_OUT,
  output logic          n_ROMO,
  output logic          n_RAMO,
  output logic          n_RAMW,
  output logic          n_SWBEN,
  output logic          LEDLTCH,
  output logic          BUSY,
  output logic          DONE,
  output logic [2:0]    St
);

  localparam int MAXC = (WR_CYCLES > HOLD_CYCLES)
                      ? WR_CYCLES : HOLD_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] WR_LAST   = CW'(WR_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SOURCE = 3'd1,
    S_WRITE  = 3'd2,
    S_HOLD   = 3'd3,
    S_NEXT   = 3'd4,
    S_WAIT   = 3'd5
  } state_t;

  state_t        st, st_nx;
  logic [2:0]    func_r, func_nx;
  logic          block_r, block_nx;
  logic [AW-1:0] add_nx;
  logic          ramw, ramw_nx;
  logic          led_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          ram_sink, led_sink;
  logic [2:0]    src_f;
  logic          src_act;

  assign ram_sink = (func_r == 3'd3) || (func_r == 3'd4);
  assign led_sink = (func_r >= 3'd5);

  // State, address, latched request and sink strobes
  always_ff @(posedge CK or negedge n_CLR) begin
    if (!n_CLR) begin
      st      <= S_IDLE;
      func_r  <= 3'd0;
      block_r <= 1'b0;
      ADD_OUT <= '0;
      ramw    <= 1'b0;
      LEDLTCH <= 1'b0;
      cnt     <= '0;
    end else begin
      st      <= st_nx;
      func_r  <= func_nx;
      block_r <= block_nx;
      ADD_OUT <= add_nx;
      ramw    <= ramw_nx;
      LEDLTCH <= led_nx;
      cnt     <= cnt_nx;
    end
  end

  // Next-state sequencing; counter clears whenever state changes
  always_comb begin
    st_nx    = st;
    func_nx  = func_r;
    block_nx = block_r;
    add_nx   = ADD_OUT;
    ramw_nx  = ramw;
    led_nx   = LEDLTCH;
    cnt_nx   = '0;
    unique case (st)
      S_IDLE: begin
        add_nx = ADD_IN;
        if (GO && (FUNC >= 3'd3)) begin
          func_nx  = FUNC;
          block_nx = BLOCK;
          st_nx    = S_SOURCE;
        end
      end
      S_SOURCE: begin
        ramw_nx = ram_sink;
        led_nx  = led_sink;
        st_nx   = S_WRITE;
      end
      S_WRITE: begin
        if (cnt == WR_LAST) begin
          ramw_nx = 1'b0;
          led_nx  = 1'b0;
          st_nx   = S_HOLD;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt == HOLD_LAST) begin
          if (block_r && ram_sink && (ADD_OUT != '1))
            st_nx = S_NEXT;
          else
            st_nx = S_WAIT;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_NEXT: begin
        add_nx = ADD_OUT + AW'(1);
        st_nx  = S_SOURCE;
      end
      S_WAIT: begin
        if (!GO) st_nx = S_IDLE;
      end
      default: st_nx = S_IDLE;
    endcase
  end

  // Source enable decode; switches stay on through the func 5 exit cycle
  always_comb begin
    src_f   = func_r;
    src_act = 1'b0;
    unique case (1'b1)
      (st == S_IDLE): begin
        src_f   = FUNC;
        src_act = (FUNC < 3'd3);
      end
      (st == S_SOURCE),
      (st == S_WRITE),
      (st == S_HOLD):
        src_act = 1'b1;
      (st == S_WAIT):
        src_act = GO || (func_r == 3'd5);
      default: src_act = 1'b0;
    endcase
    if (!n_CLR) src_act = 1'b0;
    n_ROMO  = !(src_act && (src_f inside {3'd0, 3'd4, 3'd6}));
    n_RAMO  = !(src_act && (src_f inside {3'd1, 3'd7}));
    n_SWBEN = !(src_act && (src_f inside {3'd2, 3'd3, 3'd5}));
  end

  assign n_RAMW = ~ramw;
  assign BUSY   = (st != S_IDLE);
  assign DONE   = (st == S_WAIT);
  assign St     = st;

endmodule

// File: tb/tb_playbus_seq.sv
// Bench for playbus_seq: two instances (default timing and 3/2 timing)
// against a schedule-based reference model, plus directed scenarios.
module tb_playbus_seq;

  localparam int WRC [2] = '{1, 3};
  localparam int HLC [2] = '{1, 2};

  logic       clk = 1'b0;
  logic       n_clr, go, block;
  logic [2:0] func;
  logic [3:0] add_in;

  logic [3:0] ao   [2];
  logic [2:0] sto  [2];
  logic       romo [2];
  logic       ramo [2];
  logic       ramw [2];
  logic       swb  [2];
  logic       led  [2];
  logic       bsy  [2];
  logic       dn   [2];

  int n_tests = 0;
  int n_fail  = 0;

  int m_st [2];
  int m_ad [2];
  int m_fn [2];
  int sch_st [2][256];
  int sch_ad [2][256];
  int sch_pos [2];

  always #5 clk = ~clk;

  playbus_seq #(.AW(4)) dut_a (
    .CK(clk), .n_CLR(n_clr), .GO(go), .BLOCK(block),
    .FUNC(func), .ADD_IN(add_in), .ADD_OUT(ao[0]),
    .n_ROMO(romo[0]), .n_RAMO(ramo[0]), .n_RAMW(ramw[0]),
    .n_SWBEN(swb[0]), .LEDLTCH(led[0]), .BUSY(bsy[0]),
    .DONE(dn[0]), .St(sto[0])
  );

  playbus_seq #(.AW(4), .WR_CYCLES(3), .HOLD_CYCLES(2)) dut_b (
    .CK(clk), .n_CLR(n_clr), .GO(go), .BLOCK(block),
    .FUNC(func), .ADD_IN(add_in), .ADD_OUT(ao[1]),
    .n_ROMO(romo[1]), .n_RAMO(ramo[1]), .n_RAMW(ramw[1]),
    .n_SWBEN(swb[1]), .LEDLTCH(led[1]), .BUSY(bsy[1]),
    .DONE(dn[1]), .St(sto[1])
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // whole transfer expressed as a list of per-clock (state, address)
  task automatic build(input int k);
    int n;
    int last;
    n = 0;
    last = (block && (func == 3'd3 || func == 3'd4))
         ? 15 : int'(add_in);
    for (int a = int'(add_in); a <= last; a++) begin
      sch_st[k][n] = 1; sch_ad[k][n] = a; n++;
      for (int i = 0; i < WRC[k]; i++) begin
        sch_st[k][n] = 2; sch_ad[k][n] = a; n++;
      end
      for (int i = 0; i < HLC[k]; i++) begin
        sch_st[k][n] = 3; sch_ad[k][n] = a; n++;
      end
      if (a != last) begin
        sch_st[k][n] = 4; sch_ad[k][n] = a; n++;
      end
    end
    sch_st[k][n] = 5; sch_ad[k][n] = last;
  endtask

  task automatic model_step(input int k);
    if (m_st[k] == 0) begin
      m_ad[k] = int'(add_in);
      if (go && func >= 3'd3) begin
        m_fn[k] = int'(func);
        build(k);
        m_st[k] = sch_st[k][0];
        m_ad[k] = sch_ad[k][0];
        sch_pos[k] = 1;
      end
    end else if (m_st[k] == 5) begin
      if (!go) m_st[k] = 0;
    end else begin
      m_st[k] = sch_st[k][sch_pos[k]];
      m_ad[k] = sch_ad[k][sch_pos[k]];
      sch_pos[k]++;
    end
  endtask

  always @(posedge clk or negedge n_clr) begin
    for (int k = 0; k < 2; k++) begin
      if (!n_clr) begin
        m_st[k] = 0;
        m_ad[k] = 0;
        m_fn[k] = 0;
      end else begin
        model_step(k);
      end
    end
  end

  function automatic logic [13:0] exp_vec(input int k);
    int f;
    bit act, rom, ram, sw, wr, ld;
    f = m_fn[k];
    act = 1'b0;
    case (m_st[k])
      0: begin
        f = int'(func);
        act = (func < 3'd3);
      end
      1, 2, 3: act = 1'b1;
      5: act = go || (m_fn[k] == 5);
      default: act = 1'b0;
    endcase
    if (!n_clr) act = 1'b0;
    rom = act && (f == 0 || f == 4 || f == 6);
    ram = act && (f == 1 || f == 7);
    sw  = act && (f == 2 || f == 3 || f == 5);
    wr  = (m_st[k] == 2) && (m_fn[k] == 3 || m_fn[k] == 4);
    ld  = (m_st[k] == 2) && (m_fn[k] >= 5);
    return {3'(m_st[k]), 4'(m_ad[k]), ~rom, ~ram, ~sw, ~wr, ld,
            m_st[k] != 0, m_st[k] == 5};
  endfunction

  function automatic logic [13:0] got_vec(input int k);
    return {sto[k], ao[k], romo[k], ramo[k], swb[k], ramw[k],
            led[k], bsy[k], dn[k]};
  endfunction

  always @(posedge clk) begin
    #2;
    check("mon_a", 32'(got_vec(0)), 32'(exp_vec(0)));
    check("mon_b", 32'(got_vec(1)), 32'(exp_vec(1)));
  end

  initial begin
    int nw, nr, bad, nl_a, nl_b, nr_a, nr_b, pulses, nn;
    logic [14:0] seq;
    logic [11:0] pa;
    bit prev, fin, fin_b, hit;

    n_clr = 1'b0; go = 1'b1; func = 3'd4;
    add_in = 4'd0; block = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_st", 32'(sto[0]), 32'd0);
    check("rst_en", 32'({romo[0], ramo[0], swb[0], ramw[0],
                         led[0], bsy[0]}), 32'h3C);
    check("rst_add", 32'(ao[0]), 32'd0);

    go = 1'b0; func = 3'd0; add_in = 4'd9; n_clr = 1'b1;
    #1 check("s0_romo", 32'(romo[0]), 32'd0);
    @(posedge clk); #2;
    check("s0_add", 32'(ao[0]), 32'd9);
    @(negedge clk) func = 3'd1;
    #1 check("s1_ramo", 32'(ramo[0]), 32'd0);
    @(negedge clk) func = 3'd2;
    #1 check("s2_swb", 32'(swb[0]), 32'd0);
    check("s2_st", 32'(sto[0]), 32'd0);

    @(negedge clk);
    func = 3'd4; add_in = 4'd6; go = 1'b1;
    seq = '0; nw = 0; nr = 0; bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      seq = {seq[11:0], sto[0]};
      if (!ramw[0]) nw++;
      if (!romo[0]) nr++;
      if ((sto[0] == 3'd2) != !ramw[0]) bad++;
    end
    check("f4_seq", 32'(seq), 32'(15'o12355));
    check("f4_wr", 32'(nw), 32'd1);
    check("f4_rom", 32'(nr), 32'd5);
    check("f4_wrst", 32'(bad), 32'd0);
    @(negedge clk) go = 1'b0;
    @(posedge clk); #2;
    check("f4_idle", 32'(sto[0]), 32'd0);
    repeat (4) @(negedge clk);

    func = 3'd7; go = 1'b1;
    nl_a = 0; nl_b = 0; nr_a = 0; nr_b = 0; nw = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #2;
      if (led[0]) nl_a++;
      if (led[1]) nl_b++;
      if (!ramo[0]) nr_a++;
      if (!ramo[1]) nr_b++;
      if (!ramw[0] || !ramw[1]) nw++;
      if (i == 0) begin
        @(negedge clk) go = 1'b0;
      end
    end
    check("f7_led_a", 32'(nl_a), 32'd1);
    check("f7_led_b", 32'(nl_b), 32'd3);
    check("f7_ramo_a", 32'(nr_a), 32'd3);
    check("f7_ramo_b", 32'(nr_b), 32'd6);
    check("f7_nowr", 32'(nw), 32'd0);

    @(negedge clk);
    func = 3'd4; add_in = 4'd13; block = 1'b1; go = 1'b1;
    pulses = 0; pa = '0; nn = 0; prev = 1'b1; fin = 1'b0;
    for (int i = 0; i < 40 && !fin; i++) begin
      @(posedge clk); #2;
      if (prev && !ramw[0]) begin
        pulses++;
        pa = {pa[7:0], ao[0]};
      end
      prev = ramw[0];
      if (sto[0] == 3'd4) nn++;
      if (dn[0]) fin = 1'b1;
      if (i == 1) begin
        @(negedge clk) func = 3'd0;
      end
    end
    check("blk_done", 32'(fin), 32'd1);
    check("blk_pulses", 32'(pulses), 32'd3);
    check("blk_addr", 32'(pa), 32'hDEF);
    check("blk_next", 32'(nn), 32'd2);
    fin_b = 1'b0;
    for (int i = 0; i < 40 && !fin_b; i++) begin
      @(posedge clk); #2;
      if (dn[1]) fin_b = 1'b1;
    end
    check("blkb_done", 32'(fin_b), 32'd1);
    @(negedge clk) go = 1'b0; block = 1'b0;
    repeat (3) @(negedge clk);

    func = 3'd3; add_in = 4'd2; go = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(posedge clk); #2;
      if (sto[0] == 3'd2) hit = 1'b1;
    end
    check("mr_hit", 32'(hit), 32'd1);
    check("mr_pre_wr", 32'(ramw[0]), 32'd0);
    #1 n_clr = 1'b0;
    #1;
    check("mr_st", 32'(sto[0]), 32'd0);
    check("mr_wr", 32'(ramw[0]), 32'd1);
    check("mr_st_b", 32'(sto[1]), 32'd0);
    check("mr_wr_b", 32'(ramw[1]), 32'd1);
    @(negedge clk) n_clr = 1'b1; go = 1'b0;
    @(negedge clk) add_in = 4'd5; go = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(posedge clk); #2;
      if (sto[0] == 3'd2) hit = 1'b1;
    end
    check("rs_hit", 32'(hit), 32'd1);
    check("rs_add", 32'(ao[0]), 32'd5);
    check("rs_wr", 32'(ramw[0]), 32'd0);
    @(negedge clk) go = 1'b0;
    repeat (8) @(negedge clk);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      n_clr  = ($urandom_range(0, 299) != 0);
      go     = ($urandom_range(0, 99) < 40);
      func   = 3'($urandom);
      add_in = 4'($urandom);
      block  = 1'($urandom);
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/playbus_seq.md
Name: playbus_seq

Overview:
- Parametrised PlayBus bus-cycle controller; drives the ROM, RAM, switch-buffer and LED-latch enables on the shared 8-bit data bus.
- Supports all eight functions 0-7, including RAM to LEDs.
- Adds configurable write-strobe and hold lengths, a registered address output, and an auto-incrementing block-copy mode into RAM.
- State is exported on St so the sequence can be monitored from the fixed PlayBus connections.

Parameters:
AW, 4, address bus width
WR_CYCLES, 1, clocks the write strobe (RAMW/LEDLTCH) is held active; must be >=1
HOLD_CYCLES, 1, clocks the source stays enabled after the strobe ends; must be >=1

Ports:
CK  in  1  system clock, rising edge
n_CLR  in  1  reset
GO  in  1  start request for dynamic functions, level-sensitive
BLOCK  in  1  1 = block copy for RAM-sink functions 3 and 4
FUNC  in  3  function select
ADD_IN  in  AW  address from switches
ADD_OUT  out  AW  registered address driven to ROM/RAM
n_ROMO  out  1  ROM output enable, active low
n_RAMO  out  1  RAM output enable, active low
n_RAMW  out  1  RAM write, active low; equals ~RAMW register
n_SWBEN  out  1  switch buffer enable, active low
LEDLTCH  out  1  LED latch strobe, registered, active high
BUSY  out  1  high in every state except IDLE
DONE  out  1  high in WAIT_REL
St  out  3  current state code

Behaviour:
- Reset: n_CLR is asynchronous, active-low. While low, St=0 (IDLE), RAMW=0 (so n_RAMW=1), LEDLTCH=0, ADD_OUT=0, func_r=0, counter=0. Reset mid-operation aborts the sequence immediately; no partial strobe may persist.
- All enables are combinational from St, func_r and FUNC; default inactive (1). RAMW and LEDLTCH are registered only.
- Sources:
  - ROM: functions 0, 4, 6.
  - RAM: functions 1, 7.
  - Switches: functions 2, 3, 5.
- Sinks:
  - RAM (RAMW): functions 3, 4.
  - LEDs (LEDLTCH): functions 5, 6, 7.
- States (St codes): IDLE=0, SOURCE=1, WRITE=2, HOLD=3, NEXT=4, WAIT_REL=5.
- IDLE:
  - ADD_OUT <= ADD_IN every clock.
  - FUNC 0/1/2 asserts its source enable combinationally from live FUNC.
  - FUNC 3-7 with GO=1: func_r <= FUNC, go to SOURCE.
- SOURCE (1 clk):
  - Source of func_r enabled.
  - Sink register set on exit, so the strobe is active for the whole of WRITE.
  - Go to WRITE.
- WRITE (WR_CYCLES clks):
  - Source enabled; counter counts.
  - On the last cycle the sink register is cleared; go to HOLD.
- HOLD (HOLD_CYCLES clks):
  - Source enabled, strobe inactive.
  - On the last cycle: if BLOCK=1, func_r in {3,4} and ADD_OUT != all-ones, go to NEXT; otherwise go to WAIT_REL.
- NEXT (1 clk):
  - All enables inactive while the address settles.
  - ADD_OUT <= ADD_OUT+1; go to SOURCE.
- WAIT_REL:
  - Source stays enabled while GO=1.
  - GO=0: go to IDLE.
  - For func_r=5, n_SWBEN stays low on the exit cycle.
- Rules:
  - FUNC, ADD_IN and BLOCK changes after the sequence starts are ignored until IDLE.
  - GO is ignored except in IDLE and WAIT_REL.
  - BLOCK is ignored for LED-sink functions; they always perform a single transfer.
  - Block copy ends at address 2^AW-1; it never wraps to 0.
  - The counter is wide enough for max(WR_CYCLES, HOLD_CYCLES) and clears on every state change.
- Single transfer latency, defaults: the strobe goes active on the 2nd rising edge after GO is sampled, for exactly WR_CYCLES clocks.

Test Plan:
- Reset: hold n_CLR=0 -> all enables 1, n_RAMW=1, LEDLTCH=0, St=0, BUSY=0, ADD_OUT=0. Apply FUNC=4, GO=1 during reset -> no change.
- Static: FUNC=0/1/2, GO=0 -> n_ROMO/n_RAMO/n_SWBEN respectively low, St=0; ADD_IN=9 -> ADD_OUT=9 after one edge.
- FUNC=4, ADD_IN=6, defaults, GO pulse:
  - St follows 0,1,2,3,5.
  - n_RAMW low exactly during St=2.
  - n_ROMO low in St 1-3 and in 5 while GO=1.
  - Return to 0 after GO=0.
- FUNC=7, WR_CYCLES=3, HOLD_CYCLES=2:
  - LEDLTCH high for exactly 3 clocks.
  - n_RAMO low for 1+3+2 clocks.
  - n_RAMW stays 1 throughout.
- Block copy: AW=4, BLOCK=1, FUNC=4, ADD_IN=13:
  - Exactly three n_RAMW pulses, at ADD_OUT=13, 14, 15.
  - St=4 between pulses; then St=5 with DONE=1.
  - Changing FUNC to 0 mid-block has no effect.
- Reset mid-operation: assert n_CLR=0 in St=2 with n_RAMW=0 -> n_RAMW=1 and St=0 immediately (asynchronous); the next GO restarts cleanly.
